// File: rtl/mem_stream_reader_pkg.sv
// Shared types for memory read clients: reader FSM encoding and output FIFO sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo4.sv
// First-word-fall-through FIFO of FIFO_DEPTH entries with occupancy output.
// Latency: push visible at head one cycle later; head is combinational from storage.
// Backpressure: push ignored when full (the producer sizes issue against occupancy).
module stream_fifo4
    import mem_stream_reader_pkg::*;
#(
    parameter int  W     = 5,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [W-1:0]     head_dat,
    output logic [OCC_W-1:0] occupancy
);

    logic [W-1:0]     mem_q [FIFO_DEPTH];
    logic [W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_vld && (cnt_q != OCC_W'(FIFO_DEPTH));
    assign do_pop  = pop_rdy && (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_vld  = (cnt_q != '0);
    assign head_dat  = mem_q[rd_ptr_q];
    assign occupancy = cnt_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a contiguous, wrapping address window from a 1-cycle sync-read memory and streams it out.
// Latency: first beat valid 2 cycles after the start-accept edge; 1 beat/cycle when m_ready is held.
// Backpressure: issue throttled so FIFO occupancy plus in-flight reads never exceeds FIFO_DEPTH.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int  DEPTH  = 784,
    parameter int  WIDTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LEN_W-1:0]        length,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [WIDTH-1:0] mem_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_last
);

    localparam int PEND_W = OCC_W + 1;

    rd_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        pipe_vld_q, pipe_vld_d;
    logic [1:0]        pipe_last_q, pipe_last_d;

    logic              issue, issue_last, pop;
    logic [PEND_W-1:0] pending;
    logic              fifo_head_vld;
    logic [WIDTH:0]    fifo_head_dat;
    logic [OCC_W-1:0]  fifo_occ;

    // Reserve a FIFO slot for every read still travelling through the memory.
    assign pending = {1'b0, fifo_occ} + PEND_W'(pipe_vld_q[0]) + PEND_W'(pipe_vld_q[1]);
    assign pop     = fifo_head_vld && m_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        addr_d     = addr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d = length;
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_RUN;
                        addr_d     = base_addr;
                        issue      = 1'b1;
                        issue_last = (length == LEN_W'(1));
                        issued_d   = LEN_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (issued_q == len_q) begin
                    state_d = ST_DRAIN;
                end else if (pending < PEND_W'(FIFO_DEPTH)) begin
                    issue      = 1'b1;
                    issue_last = (issued_q == len_q - LEN_W'(1));
                    issued_d   = issued_q + LEN_W'(1);
                    addr_d     = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head_dat[WIDTH]) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                issued_d = '0;
            end
        endcase
        pipe_vld_d  = {pipe_vld_q[0], issue};
        pipe_last_d = {pipe_last_q[0], issue_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            addr_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            addr_q      <= addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    stream_fifo4 #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (pipe_vld_q[1]),
        .push_dat  ({pipe_last_q[1], mem_data}),
        .pop_rdy   (pop),
        .head_vld  (fifo_head_vld),
        .head_dat  (fifo_head_dat),
        .occupancy (fifo_occ)
    );

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign mem_addr = addr_q;
    assign m_valid  = fifo_head_vld;
    assign m_data   = fifo_head_dat[WIDTH-1:0];
    assign m_last   = fifo_head_dat[WIDTH];

endmodule
